// File: rtl/ex_simple_pipe_pkg.sv
// ex_simple_pipe_pkg
//   Shared definitions for the single-issue execute pipe: default widths
//   for operands, aluop, ROB tag, RS age tag and register address, and the
//   aluop encodings understood by ex_simple_pipe_alu.
package ex_simple_pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 6;
  localparam int DEF_ROB_W  = 4;
  localparam int DEF_AGE_W  = 3;
  localparam int REG_W      = 5;

  // Any encoding not listed here produces a zero result.
  typedef enum logic [DEF_OP_W-1:0] {
    ALU_ADD  = 6'd0,
    ALU_SUB  = 6'd1,
    ALU_AND  = 6'd2,
    ALU_OR   = 6'd3,
    ALU_XOR  = 6'd4,
    ALU_SLL  = 6'd5,
    ALU_SRL  = 6'd6,
    ALU_SRA  = 6'd7,
    ALU_SLT  = 6'd8,
    ALU_SLTU = 6'd9
  } aluop_e;

endpackage

// File: rtl/ex_simple_pipe_alu.sv
// ex_simple_pipe_alu
//   Purely combinational integer ALU.
//   Ports:
//     a, b : operands (DATA_W)
//     op   : aluop (OP_W), encodings from ex_simple_pipe_pkg::aluop_e
//     y    : result (DATA_W); zero for unknown encodings
module ex_simple_pipe_alu
  import ex_simple_pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = b[SH_W-1:0];

  always_comb begin
    // NOTE: every path assigns y, starting from a default, so no latch is inferred.
    y = '0;
    case (op)
      OP_W'(ALU_ADD):  y = a + b;
      OP_W'(ALU_SUB):  y = a - b;
      OP_W'(ALU_AND):  y = a & b;
      OP_W'(ALU_OR):   y = a | b;
      OP_W'(ALU_XOR):  y = a ^ b;
      OP_W'(ALU_SLL):  y = a << shamt;
      OP_W'(ALU_SRL):  y = a >> shamt;
      OP_W'(ALU_SRA):  y = $signed(a) >>> shamt;
      OP_W'(ALU_SLT):  y = DATA_W'($signed(a) < $signed(b));
      OP_W'(ALU_SLTU): y = DATA_W'(a < b);
      default:         y = '0;
    endcase
  end

endmodule

// File: rtl/ex_simple_pipe.sv
// ex_simple_pipe
//   Single-issue execute stage. Picks the oldest ready RS entry (smallest
//   age, ties to the lowest index), runs it through the ALU and captures
//   the result in a one-deep result register that hands off to the ROB/RF
//   with a valid/ready handshake.
//   Ports:
//     clk, rst_n           : clock, async active-low reset
//     flush                : squash the held result and block issue
//     rs_*                 : packed per-entry RS fields (entry i at [i*W +: W])
//     rs_issue             : one-hot grant, combinational
//     wb_valid/wb_ready    : result handshake
//     wb_data/addr/rob_num/regwrite : held result
//     rf_we                : register-file write strobe for this cycle
//     issue_cnt            : free-running count of grants (wraps)
module ex_simple_pipe
  import ex_simple_pipe_pkg::*;
#(
  parameter int NUM_RS = 2,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W,
  parameter int ROB_W  = DEF_ROB_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_RS-1:0]        rs_valid,
  input  logic [NUM_RS-1:0]        rs_src1_rdy,
  input  logic [NUM_RS-1:0]        rs_src2_rdy,
  input  logic [NUM_RS*DATA_W-1:0] rs_src1,
  input  logic [NUM_RS*DATA_W-1:0] rs_src2,
  input  logic [NUM_RS*OP_W-1:0]   rs_aluop,
  input  logic [NUM_RS*REG_W-1:0]  rs_rd,
  input  logic [NUM_RS-1:0]        rs_regwrite,
  input  logic [NUM_RS*ROB_W-1:0]  rs_rob_num,
  input  logic [NUM_RS*AGE_W-1:0]  rs_age,
  output logic [NUM_RS-1:0]        rs_issue,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [REG_W-1:0]         wb_addr,
  output logic [ROB_W-1:0]         wb_rob_num,
  output logic                     wb_regwrite,
  output logic                     rf_we,
  output logic [15:0]              issue_cnt
);

  localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

  logic [NUM_RS-1:0] eligible;
  logic [NUM_RS-1:0] grant_oh;
  logic              found;
  logic [IDX_W-1:0]  sel_idx;
  logic [AGE_W-1:0]  best_age;
  logic              can_issue;
  logic              issue_go;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_y;
  logic [REG_W-1:0]  sel_rd;
  logic [ROB_W-1:0]  sel_rob;
  logic              sel_rw;

  assign eligible = rs_valid & rs_src1_rdy & rs_src2_rdy;

  // Age selector: a strictly-smaller comparison keeps the first (lowest
  // index) entry among equal ages.
  always_comb begin
    found    = 1'b0;
    sel_idx  = '0;
    best_age = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      if (eligible[i] && (!found || rs_age[i*AGE_W +: AGE_W] < best_age)) begin
        found    = 1'b1;
        sel_idx  = IDX_W'(i);
        best_age = rs_age[i*AGE_W +: AGE_W];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (found) grant_oh[sel_idx] = 1'b1;
  end

  // rst_n is included so no grant is visible while reset is held, even
  // though wb_valid is already forced low then.
  assign can_issue = (!wb_valid || wb_ready) && !flush && rst_n;
  assign rs_issue  = can_issue ? grant_oh : '0;
  assign issue_go  = |rs_issue;

  // Operands are zeroed when nothing is eligible so the ALU does not
  // follow stale RS contents.
  assign alu_a   = found ? rs_src1[sel_idx*DATA_W +: DATA_W] : '0;
  assign alu_b   = found ? rs_src2[sel_idx*DATA_W +: DATA_W] : '0;
  assign alu_op  = found ? rs_aluop[sel_idx*OP_W +: OP_W]    : '0;
  assign sel_rd  = rs_rd[sel_idx*REG_W +: REG_W];
  assign sel_rob = rs_rob_num[sel_idx*ROB_W +: ROB_W];
  assign sel_rw  = rs_regwrite[sel_idx];

  ex_simple_pipe_alu #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  assign rf_we = wb_valid && wb_ready && wb_regwrite;

  // A grant implies the slot is empty or retiring this edge, so loading
  // on grant covers the simultaneous retire+load case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_addr     <= '0;
      wb_rob_num  <= '0;
      wb_regwrite <= 1'b0;
      issue_cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (flush) begin
        wb_valid <= 1'b0;
      end else if (issue_go) begin
        wb_valid    <= 1'b1;
        wb_data     <= alu_y;
        wb_addr     <= sel_rd;
        wb_rob_num  <= sel_rob;
        wb_regwrite <= sel_rw;
      end else if (wb_valid && wb_ready) begin
        wb_valid <= 1'b0;
      end
      if (issue_go) issue_cnt <= issue_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ex_simple_pipe.sv
// tb_ex_simple_pipe
//   Directed scenarios plus a randomized run against a behavioural model of
//   the oldest-first issue stage and its one-deep result register.
module tb_ex_simple_pipe;
  import ex_simple_pipe_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int OW = 6;
  localparam int RW = 4;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    rs_valid, rs_src1_rdy, rs_src2_rdy, rs_regwrite;
  logic [N*DW-1:0] rs_src1, rs_src2;
  logic [N*OW-1:0] rs_aluop;
  logic [N*5-1:0]  rs_rd;
  logic [N*RW-1:0] rs_rob_num;
  logic [N*AW-1:0] rs_age;
  logic [N-1:0]    rs_issue;
  logic            wb_valid, wb_ready, wb_regwrite, rf_we;
  logic [DW-1:0]   wb_data;
  logic [4:0]      wb_addr;
  logic [RW-1:0]   wb_rob_num;
  logic [15:0]     issue_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model of the result register.
  logic          m_valid, m_rw;
  logic [DW-1:0] m_data;
  logic [4:0]    m_addr;
  logic [RW-1:0] m_rob;
  logic [15:0]   m_cnt;

  always #5 clk = ~clk;

  ex_simple_pipe #(
    .NUM_RS (N), .DATA_W (DW), .OP_W (OW), .ROB_W (RW), .AGE_W (AW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .rs_valid (rs_valid), .rs_src1_rdy (rs_src1_rdy), .rs_src2_rdy (rs_src2_rdy),
    .rs_src1 (rs_src1), .rs_src2 (rs_src2), .rs_aluop (rs_aluop), .rs_rd (rs_rd),
    .rs_regwrite (rs_regwrite), .rs_rob_num (rs_rob_num), .rs_age (rs_age),
    .rs_issue (rs_issue), .wb_valid (wb_valid), .wb_ready (wb_ready),
    .wb_data (wb_data), .wb_addr (wb_addr), .wb_rob_num (wb_rob_num),
    .wb_regwrite (wb_regwrite), .rf_we (rf_we), .issue_cnt (issue_cnt)
  );

  // Oldest-first: scan ages from oldest upward, first matching index wins.
  function automatic int exp_sel();
    for (int a = 0; a < (1 << AW); a++)
      for (int i = 0; i < N; i++)
        if (rs_valid[i] && rs_src1_rdy[i] && rs_src2_rdy[i] && rs_age[i*AW +: AW] == AW'(a))
          return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sh;
    longint sa;
    sh = int'(b % 32);
    sa = longint'($signed(a));
    case (int'(op))
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return DW'(sa >>> sh);
      8: return (sa < longint'($signed(b))) ? 1 : 0;
      9: return (a < b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rs();
    rs_valid = '0; rs_src1_rdy = '0; rs_src2_rdy = '0; rs_regwrite = '0;
    rs_src1 = '0; rs_src2 = '0; rs_aluop = '0; rs_rd = '0; rs_rob_num = '0; rs_age = '0;
  endtask

  task automatic set_entry(input int i, input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                           input logic [OW-1:0] op, input logic [4:0] rd, input logic rw,
                           input logic [RW-1:0] rob, input logic [AW-1:0] age);
    rs_valid[i] = 1'b1; rs_src1_rdy[i] = 1'b1; rs_src2_rdy[i] = 1'b1;
    rs_src1[i*DW +: DW] = s1; rs_src2[i*DW +: DW] = s2; rs_aluop[i*OW +: OW] = op;
    rs_rd[i*5 +: 5] = rd; rs_regwrite[i] = rw; rs_rob_num[i*RW +: RW] = rob; rs_age[i*AW +: AW] = age;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b0; clear_rs();
    tick();
    tick();
    rst_n = 1'b1;
    m_valid = 1'b0; m_rw = 1'b0; m_data = '0; m_addr = '0; m_rob = '0; m_cnt = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1; clear_rs();
    set_entry(0, 32'h5, 32'h6, 6'd0, 5'd1, 1'b1, 4'h1, 3'd0);
    #1;
    n_cmp++; if (rs_issue !== 4'b0000) begin n_fail++; $display("FAIL reset rs_issue: got %b exp 0000", rs_issue); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset wb_valid: got %b exp 0", wb_valid); end
    n_cmp++; if ({wb_data, wb_addr, wb_rob_num, wb_regwrite} !== '0) begin n_fail++;
      $display("FAIL reset wb_fields: got %h/%h/%h/%b exp zeros", wb_data, wb_addr, wb_rob_num, wb_regwrite); end
    n_cmp++; if (issue_cnt !== 16'd0) begin n_fail++; $display("FAIL reset issue_cnt: got %0d exp 0", issue_cnt); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset rf_we: got %b exp 0", rf_we); end
    n_cmp++; if (rs_issue !== 4'b0000) begin n_fail++; $display("FAIL reset rs_issue_held: got %b exp 0000", rs_issue); end
    clear_rs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_age_select();
    clear_rs(); wb_ready = 1'b1;
    set_entry(1, 32'd1, 32'd2, 6'd0, 5'd4, 1'b1, 4'h9, 3'd5);
    set_entry(3, 32'd3, 32'd4, 6'd0, 5'd5, 1'b1, 4'hC, 3'd2);
    #2;
    n_cmp++; if (rs_issue !== 4'b1000) begin n_fail++; $display("FAIL age_sel rs_issue: got %b exp 1000", rs_issue); end
    tick();
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL age_sel wb_valid: got %b exp 1", wb_valid); end
    n_cmp++; if (wb_rob_num !== 4'hC) begin n_fail++; $display("FAIL age_sel wb_rob_num: got %h exp c", wb_rob_num); end
    n_cmp++; if (wb_data !== 32'd7) begin n_fail++; $display("FAIL age_sel wb_data: got %h exp 7", wb_data); end
  endtask

  task automatic test_tie();
    clear_rs(); wb_ready = 1'b1;
    set_entry(0, 32'd10, 32'd3, 6'd1, 5'd2, 1'b1, 4'h2, 3'd4);
    set_entry(2, 32'd10, 32'd4, 6'd1, 5'd6, 1'b1, 4'h6, 3'd4);
    #2;
    n_cmp++; if (rs_issue !== 4'b0001) begin n_fail++; $display("FAIL tie rs_issue: got %b exp 0001", rs_issue); end
    tick();
    n_cmp++; if (wb_data !== 32'd7 || wb_rob_num !== 4'h2) begin n_fail++;
      $display("FAIL tie wb: got %h/%h exp 7/2", wb_data, wb_rob_num); end
  endtask

  task automatic test_add_stall();
    clear_rs(); wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    set_entry(0, 32'hFFFF_FFFF, 32'h1, 6'd0, 5'd7, 1'b1, 4'h3, 3'd0);
    #2;
    n_cmp++; if (rs_issue !== 4'b0001) begin n_fail++; $display("FAIL stall first_issue: got %b exp 0001", rs_issue); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL stall rf_we_pre: got %b exp 0", rf_we); end
    tick();
    // A different instruction stays eligible; it must not issue while stalled.
    set_entry(0, 32'h10, 32'h20, 6'd0, 5'd3, 1'b1, 4'h4, 3'd0);
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (rs_issue !== 4'b0000) begin n_fail++; $display("FAIL stall rs_issue c%0d: got %b exp 0000", c, rs_issue); end
      n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL stall rf_we c%0d: got %b exp 0", c, rf_we); end
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== 32'h0 || wb_addr !== 5'd7) begin n_fail++;
        $display("FAIL stall hold c%0d: got v=%b d=%h a=%0d exp v=1 d=0 a=7", c, wb_valid, wb_data, wb_addr); end
      tick();
    end
    clear_rs(); wb_ready = 1'b1;
    #2;
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL stall rf_we_release: got %b exp 1", rf_we); end
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL stall retire: got %b exp 0", wb_valid); end
    n_cmp++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL stall rf_we_after: got %b exp 0", rf_we); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    do_reset();
    wb_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      clear_rs();
      a = $urandom(); b = $urandom();
      set_entry(c % N, a, b, 6'd4, 5'(c + 1), 1'b1, 4'(c), 3'(c));
      #2;
      n_cmp++; if (rs_issue !== 4'(1 << (c % N))) begin n_fail++; $display("FAIL b2b issue c%0d: got %b", c, rs_issue); end
      tick();
      n_cmp++; if (wb_valid !== 1'b1 || wb_data !== (a ^ b)) begin n_fail++;
        $display("FAIL b2b wb c%0d: got v=%b d=%h exp v=1 d=%h", c, wb_valid, wb_data, a ^ b); end
    end
    n_cmp++; if (issue_cnt !== 16'd5) begin n_fail++; $display("FAIL b2b issue_cnt: got %0d exp 5", issue_cnt); end
    clear_rs();
    tick();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b drain: got %b exp 0", wb_valid); end
  endtask

  task automatic test_flush();
    clear_rs(); wb_ready = 1'b1;
    set_entry(1, 32'd8, 32'd9, 6'd0, 5'd9, 1'b1, 4'h5, 3'd1);
    tick();
    set_entry(1, 32'd1, 32'd1, 6'd0, 5'd10, 1'b1, 4'h6, 3'd1);
    flush = 1'b1;
    #2;
    n_cmp++; if (rs_issue !== 4'b0000) begin n_fail++; $display("FAIL flush rs_issue: got %b exp 0000", rs_issue); end
    n_cmp++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL flush rf_we: got %b exp 1", rf_we); end
    tick();
    flush = 1'b0; clear_rs();
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush wb_valid: got %b exp 0", wb_valid); end
    n_cmp++; if (issue_cnt !== 16'd6) begin n_fail++; $display("FAIL flush issue_cnt: got %0d exp 6", issue_cnt); end
  endtask

  task automatic test_async_reset();
    clear_rs(); wb_ready = 1'b0;
    set_entry(2, 32'd2, 32'd2, 6'd0, 5'd1, 1'b1, 4'h1, 3'd0);
    tick();
    n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL areset setup: got %b exp 1", wb_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL areset wb_valid: got %b exp 0", wb_valid); end
    n_cmp++; if (issue_cnt !== 16'd0) begin n_fail++; $display("FAIL areset issue_cnt: got %0d exp 0", issue_cnt); end
    n_cmp++; if (rs_issue !== 4'b0000) begin n_fail++; $display("FAIL areset rs_issue: got %b exp 0000", rs_issue); end
    #1;
    rst_n = 1'b1;
    clear_rs();
    tick();
  endtask

  task automatic test_random();
    int sel;
    logic [N-1:0] exp_issue;
    logic exp_rfwe;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        rs_valid[i]    = ($urandom_range(0, 3) != 0);
        rs_src1_rdy[i] = ($urandom_range(0, 3) != 0);
        rs_src2_rdy[i] = ($urandom_range(0, 3) != 0);
        rs_src1[i*DW +: DW] = $urandom();
        rs_src2[i*DW +: DW] = ($urandom_range(0, 1) != 0) ? $urandom() : DW'($urandom_range(0, 40));
        rs_aluop[i*OW +: OW] = ($urandom_range(0, 7) != 0) ? OW'($urandom_range(0, 9)) : OW'($urandom_range(10, 63));
        rs_rd[i*5 +: 5] = 5'($urandom());
        rs_regwrite[i] = 1'($urandom());
        rs_rob_num[i*RW +: RW] = RW'($urandom());
        rs_age[i*AW +: AW] = AW'($urandom());
      end
      wb_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #2;
      sel = exp_sel();
      exp_issue = ((!m_valid || wb_ready) && !flush && sel >= 0) ? N'(1 << sel) : '0;
      exp_rfwe = m_valid && wb_ready && m_rw;
      n_cmp++; if (rs_issue !== exp_issue) begin n_fail++; $display("FAIL rand rs_issue c%0d: got %b exp %b", c, rs_issue, exp_issue); end
      n_cmp++; if (rf_we !== exp_rfwe) begin n_fail++; $display("FAIL rand rf_we c%0d: got %b exp %b", c, rf_we, exp_rfwe); end
      if (flush) m_valid = 1'b0;
      else if (exp_issue != '0) begin
        m_valid = 1'b1;
        m_data  = alu_ref(rs_aluop[sel*OW +: OW], rs_src1[sel*DW +: DW], rs_src2[sel*DW +: DW]);
        m_addr  = rs_rd[sel*5 +: 5];
        m_rob   = rs_rob_num[sel*RW +: RW];
        m_rw    = rs_regwrite[sel];
      end else if (m_valid && wb_ready) m_valid = 1'b0;
      if (exp_issue != '0) m_cnt = m_cnt + 16'd1;
      tick();
      n_cmp++; if (wb_valid !== m_valid) begin n_fail++; $display("FAIL rand wb_valid c%0d: got %b exp %b", c, wb_valid, m_valid); end
      if (m_valid) begin
        n_cmp++; if ({wb_data, wb_addr, wb_rob_num, wb_regwrite} !== {m_data, m_addr, m_rob, m_rw}) begin n_fail++;
          $display("FAIL rand wb c%0d: got %h/%0d/%h/%b exp %h/%0d/%h/%b", c,
                   wb_data, wb_addr, wb_rob_num, wb_regwrite, m_data, m_addr, m_rob, m_rw); end
      end
      n_cmp++; if (issue_cnt !== m_cnt) begin n_fail++; $display("FAIL rand issue_cnt c%0d: got %0d exp %0d", c, issue_cnt, m_cnt); end
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_age_select();
    test_tie();
    test_add_stall();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_simple_pipe.md
EX_SIMPLE_PIPE -- requirements
Module: ex_simple_pipe

Interface
REQ-001 Parameters SHALL be:
- NUM_RS, 2, number of RS entries arbitrated (2..8).
- DATA_W, 32, operand/result width.
- OP_W, 6, aluop width.
- ROB_W, 4, ROB entry-number width.
- AGE_W, 3, RS age-tag width.
REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  squash everything in flight.
- rs_valid  in  NUM_RS  entry holds an instruction.
- rs_src1_rdy, rs_src2_rdy  in  NUM_RS each  operand ready bits.
- rs_src1, rs_src2  in  NUM_RS*DATA_W  packed operands (entry i at [i*DATA_W +: DATA_W]).
- rs_aluop  in  NUM_RS*OP_W  packed aluop.
- rs_rd  in  NUM_RS*5  packed destination register.
- rs_regwrite  in  NUM_RS  destination is written.
- rs_rob_num  in  NUM_RS*ROB_W  packed ROB entry number.
- rs_age  in  NUM_RS*AGE_W  packed age; smaller is older.
- rs_issue  out  NUM_RS  one-hot grant; RS frees that entry at the clock edge.
- wb_valid  out  1  result register holds a result.
- wb_ready  in  1  ROB/RF accepts the result this cycle.
- wb_data  out  DATA_W  ALU result.
- wb_addr  out  5  destination register.
- wb_rob_num  out  ROB_W  ROB entry number.
- wb_regwrite  out  1  regwrite of held result.
- rf_we  out  1  = wb_valid & wb_ready & wb_regwrite.
- issue_cnt  out  16  count of issued instructions.
REQ-003 One clock; reset is asynchronous and active-low; ports named clk and rst_n.

Function
REQ-004 Entry i SHALL be eligible when rs_valid[i] & rs_src1_rdy[i] & rs_src2_rdy[i].
REQ-005 Selection SHALL grant the eligible entry with the smallest rs_age; ties go to the lowest index.
REQ-006 can_issue SHALL be (!wb_valid | wb_ready) & !flush; rs_issue SHALL be the one-hot grant gated by can_issue, else all zero.
REQ-007 rs_issue SHALL be combinational, same cycle as eligibility.
REQ-008 The selected operands and aluop SHALL feed the alu combinationally; the result, rd, rob_num and regwrite SHALL be captured in the result register on the edge where a grant is asserted (latency 1 cycle, issue to wb_valid).
REQ-009 Result register transitions per edge:
- flush: wb_valid <= 0.
- grant: load, wb_valid <= 1.
- wb_valid & wb_ready & no grant: wb_valid <= 0.
- wb_valid & !wb_ready: hold all wb_* stable.
REQ-010 Back-to-back: with wb_ready held 1, one instruction SHALL issue per cycle (throughput 1).
REQ-011 Simultaneous wb handshake and new grant SHALL retire the old result and load the new one in the same edge.
REQ-012 flush SHALL override grant and handshake; rf_we SHALL still reflect the current-cycle handshake.
REQ-013 issue_cnt SHALL increment by 1 per grant and wrap from 0xFFFF to 0x0000; flush does not clear it.
REQ-014 No eligible entry: rs_issue = 0, alu inputs driven to 0.

Reset
REQ-015 While rst_n = 0: wb_valid, wb_data, wb_addr, wb_rob_num, wb_regwrite, issue_cnt = 0; rs_issue and rf_we = 0.
REQ-016 Reset assertion mid-operation SHALL discard the held result immediately, without waiting for a clock edge.

Structure
REQ-017 A shared package SHALL hold the default widths (DATA_W, OP_W, ROB_W, AGE_W, register-address width 5) and the aluop encodings.
REQ-018 The existing alu module SHALL be the single sub-module, instantiated once; the age-based selector SHALL be inline logic.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- NUM_RS=4; entries 1 and 3 eligible, ages 5 and 2; wb_ready=1 -> rs_issue=4'b1000; next cycle wb_valid=1, wb_rob_num = entry 3's number.
- Entries 0 and 2 eligible, equal age 4 -> rs_issue=4'b0001.
- ADD of 0xFFFFFFFF + 1, regwrite=1, rd=7; wb_ready=0 for 3 cycles -> wb_data=0 and wb_addr=7 held, rs_issue=0 throughout; rf_we=1 only in the cycle wb_ready rises.
- Eligible entry every cycle for 5 cycles, wb_ready=1 -> 5 consecutive wb_valid cycles, issue_cnt=5.
- flush with wb_valid=1 and an eligible entry -> rs_issue=0; next cycle wb_valid=0.
- rst_n pulsed low between edges while wb_valid=1 -> wb_valid=0 immediately, issue_cnt=0.
